// File: rtl/stat_display_scan.sv
// Statistics counter reader: samples one 16-bit counter, converts it to BCD (double dabble)
// and scans it onto an 8-digit 7-segment display. Build macro: LEAD_ZERO_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for refresh tick, select change or pending request
// LOAD  | latch selected counter, clear BCD accumulator
// SHIFT | 16 add-3/shift iterations
// DONE  | commit accumulator to display register, pulse upd
module stat_display_scan #(
   parameter int SCAN_DIV    = 1000,
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  sel,
   input  logic [15:0] cnt_sum,
   input  logic [15:0] cnt_j,
   input  logic [15:0] cnt_b,
   input  logic [15:0] cnt_bs,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        busy,
   output logic        upd
);
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int REFR_W = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic                pending_q, pending_d;
   logic [1:0]          sel_q;
   logic [REFR_W-1:0]   refresh_q, refresh_d;
   logic [SCAN_W-1:0]   scan_q, scan_d;
   logic [2:0]          ptr_q, ptr_d;
   logic [15:0]         bin_q, bin_d;
   logic [19:0]         bcd_q, bcd_d, bcd_adj;
   logic [3:0]          bit_cnt_q, bit_cnt_d;
   logic [19:0]         disp_q, disp_d;
   logic                upd_q, upd_d;
   logic [7:0]          an_q, seg_q, seg_d;
   logic [15:0]         sel_cnt;
   logic                refresh_wrap, trigger;
   logic [4:1]          lz;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   assign refresh_wrap = (refresh_q == REFR_W'(REFRESH_DIV - 1));
   assign trigger      = refresh_wrap | (sel != sel_q);

   always_comb begin
      case (sel)
         2'd0:    sel_cnt = cnt_sum;
         2'd1:    sel_cnt = cnt_j;
         2'd2:    sel_cnt = cnt_b;
         default: sel_cnt = cnt_bs;
      endcase
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      bit_cnt_d = bit_cnt_q;
      disp_d    = disp_q;
      upd_d     = 1'b0;
      // Requests arriving mid-conversion collapse into a single follow-up run.
      if (state_q != S_IDLE && trigger) pending_d = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (trigger || pending_q) begin
               pending_d = 1'b0;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            bin_d     = sel_cnt;
            bcd_d     = '0;
            bit_cnt_d = '0;
            state_d   = S_SHIFT;
         end
         S_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
            bit_cnt_d      = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) state_d = S_DONE;
         end
         S_DONE: begin
            disp_d  = bcd_q;
            upd_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      refresh_d = refresh_wrap ? '0 : refresh_q + REFR_W'(1);
      scan_d    = scan_q + SCAN_W'(1);
      ptr_d     = ptr_q;
      if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
         scan_d = '0;
         ptr_d  = ptr_q + 3'd1;
      end
   end

`ifdef LEAD_ZERO_BLANK_EN
   assign lz[4] = (disp_q[19:16] == 4'd0);
   assign lz[3] = lz[4] && (disp_q[15:12] == 4'd0);
   assign lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
   assign lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
`else
   assign lz = '0;
`endif

   always_comb begin
      case (ptr_q)
         3'd0:    seg_d = seg7(disp_q[3:0]);
         3'd1:    seg_d = lz[1] ? 8'hFF : seg7(disp_q[7:4]);
         3'd2:    seg_d = lz[2] ? 8'hFF : seg7(disp_q[11:8]);
         3'd3:    seg_d = lz[3] ? 8'hFF : seg7(disp_q[15:12]);
         3'd4:    seg_d = lz[4] ? 8'hFF : seg7(disp_q[19:16]);
         3'd7:    seg_d = seg7({2'b00, sel_q});
         default: seg_d = 8'hFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pending_q <= 1'b1;
         sel_q     <= '0;
         refresh_q <= '0;
         scan_q    <= '0;
         ptr_q     <= '0;
         bin_q     <= '0;
         bcd_q     <= '0;
         bit_cnt_q <= '0;
         disp_q    <= '0;
         upd_q     <= 1'b0;
         an_q      <= 8'hFF;
         seg_q     <= 8'hFF;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         sel_q     <= sel;
         refresh_q <= refresh_d;
         scan_q    <= scan_d;
         ptr_q     <= ptr_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         bit_cnt_q <= bit_cnt_d;
         disp_q    <= disp_d;
         upd_q     <= upd_d;
         // an and seg share one register stage so digit enable and content switch together.
         an_q      <= ~(8'b1 << ptr_q);
         seg_q     <= seg_d;
      end
   end

   assign an   = an_q;
   assign seg  = seg_q;
   assign busy = (state_q != S_IDLE);
   assign upd  = upd_q;

endmodule

// File: tb/tb_stat_display_scan.sv
// Self-checking bench for stat_display_scan: cycle-by-cycle comparison against a timeline
// model of the display, plus literal digit checks for the documented scenarios.
module tb_stat_display_scan;
   localparam int SCAN_DIV    = 4;
   localparam int REFRESH_DIV = 64;
   localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   localparam int P10 [5] = '{1, 10, 100, 1000, 10000};
`ifdef LEAD_ZERO_BLANK_EN
   localparam logic [7:0] LZ = 8'hFF;
`else
   localparam logic [7:0] LZ = 8'hC0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [15:0] cnt_sum = 16'd0, cnt_j = 16'd0, cnt_b = 16'd0, cnt_bs = 16'd0;
   logic [7:0]  an, seg;
   logic        busy, upd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stat_display_scan #(.SCAN_DIV(SCAN_DIV), .REFRESH_DIV(REFRESH_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel),
      .cnt_sum(cnt_sum), .cnt_j(cnt_j), .cnt_b(cnt_b), .cnt_bs(cnt_bs),
      .an(an), .seg(seg), .busy(busy), .upd(upd)
   );

   // Timeline model: n = edges since release, s = edge a conversion was accepted.
   int         n = 0, s = -100, latched = 0, disp_m = 0, ptr_prev = 0;
   bit         pend = 1'b1, trig = 1'b0;
   logic [1:0] selq_m = 2'd0;
   logic [7:0] exp_an = 8'hFF, exp_seg = 8'hFF;
   logic       exp_busy = 1'b0, exp_upd = 1'b0;

   function automatic logic [7:0] digit_code(int ptr, int val, logic [1:0] sq);
      if (ptr == 7) return SEG_TAB[sq];
      if (ptr == 5 || ptr == 6) return 8'hFF;
`ifdef LEAD_ZERO_BLANK_EN
      if (ptr > 0 && val < P10[ptr]) return 8'hFF;
`endif
      return SEG_TAB[(val / P10[ptr]) % 10];
   endfunction

   function automatic int pick_cnt();
      case (sel)
         2'd0:    return int'(cnt_sum);
         2'd1:    return int'(cnt_j);
         2'd2:    return int'(cnt_b);
         default: return int'(cnt_bs);
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n = 0; s = -100; pend = 1'b1; disp_m = 0; latched = 0; selq_m = 2'd0;
         exp_an = 8'hFF; exp_seg = 8'hFF; exp_busy = 1'b0; exp_upd = 1'b0;
      end else begin
         ptr_prev = (n / SCAN_DIV) % 8;
         exp_an   = ~(8'd1 << ptr_prev);
         exp_seg  = digit_code(ptr_prev, disp_m, selq_m);
         n++;
         trig    = ((n % REFRESH_DIV) == 0) || (sel != selq_m);
         selq_m  = sel;
         exp_upd = 1'b0;
         if (s > 0 && n >= s + 1 && n <= s + 18) begin
            if (n == s + 1) latched = pick_cnt();
            if (trig) pend = 1'b1;
            if (n == s + 18) begin
               disp_m  = latched;
               exp_upd = 1'b1;
            end
         end else if (trig || pend) begin
            s    = n;
            pend = 1'b0;
         end
         exp_busy = (s > 0) && (n >= s) && (n <= s + 17);
      end
   end

   task automatic chk8(string name, logic [7:0] act, logic [7:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic chk_int(string name, int act, int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      chk8("an", an, exp_an);
      chk8("seg", seg, exp_seg);
      chk8("busy", {7'd0, busy}, {7'd0, exp_busy});
      chk8("upd", {7'd0, upd}, {7'd0, exp_upd});
   end

   task automatic check_digit(int d, logic [7:0] want, string name);
      logic [7:0] target;
      bit seen;
      target = ~(8'd1 << d);
      seen   = 1'b0;
      for (int k = 0; k < 8 * SCAN_DIV + 4; k++) begin
         @(negedge clk);
         if (an == target) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk8({name, " an timeout"}, an, target);
      else       chk8(name, seg, want);
   endtask

   task automatic wait_upd(int bound, output int cyc);
      cyc = -1;
      for (int k = 1; k <= bound; k++) begin
         @(posedge clk);
         #1;
         if (upd) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic sync_phase(int ph);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 3 * REFRESH_DIV; k++) begin
         @(negedge clk);
         if ((n % REFRESH_DIV) == ph) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk_int("sync_phase reached", 0, 1);
   endtask

   function automatic logic [15:0] rand_val();
      case ($urandom_range(0, 5))
         0:       return 16'd0;
         1:       return 16'hFFFF;
         2:       return 16'd9999;
         3:       return 16'd10000;
         default: return 16'($urandom_range(0, 65535));
      endcase
   endfunction

   int c, ucnt, idle;
   logic [7:0] prev_an;
   bit found;

   initial begin
      // reset state and first conversion latency
      repeat (3) @(negedge clk);
      chk8("reset an", an, 8'hFF);
      chk8("reset seg", seg, 8'hFF);
      chk8("reset busy", {7'd0, busy}, 8'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      wait_upd(40, c);
      chk_int("first upd latency", c, 19);
      check_digit(0, 8'hC0, "zero d0");
      check_digit(4, LZ, "zero d4");
      check_digit(7, 8'hC0, "zero d7");

      // 12345 on cnt_sum via refresh
      @(negedge clk); cnt_sum = 16'd12345;
      repeat (90) @(negedge clk);
      check_digit(0, 8'h92, "12345 d0");
      check_digit(1, 8'h99, "12345 d1");
      check_digit(2, 8'hB0, "12345 d2");
      check_digit(3, 8'hA4, "12345 d3");
      check_digit(4, 8'hF9, "12345 d4");
      check_digit(5, 8'hFF, "12345 d5");
      check_digit(6, 8'hFF, "12345 d6");
      check_digit(7, 8'hC0, "12345 d7");

      // 65535 on cnt_bs, input disturbed mid-shift
      sync_phase(30);
      sel = 2'd3; cnt_bs = 16'hFFFF;
      repeat (6) @(negedge clk);
      cnt_bs = 16'h1234;
      wait_upd(40, c);
      chk_int("sel-change upd latency", c, 13);
      @(negedge clk); cnt_bs = 16'hFFFF;
      check_digit(0, 8'h92, "65535 d0");
      check_digit(1, 8'hB0, "65535 d1");
      check_digit(2, 8'h92, "65535 d2");
      check_digit(3, 8'h92, "65535 d3");
      check_digit(4, 8'h82, "65535 d4");
      check_digit(7, 8'hB0, "65535 d7");

      // sel change during SHIFT produces exactly one follow-up conversion
      @(negedge clk); sel = 2'd0; cnt_b = 16'd42;
      repeat (100) @(negedge clk);
      sync_phase(5);
      sel = 2'd2;
      ucnt = 0; idle = 0;
      for (int k = 0; k < 45; k++) begin
         @(posedge clk); #1;
         if (upd) ucnt++;
         if (ucnt < 2 && !busy) idle++;
      end
      chk_int("pending upd count", ucnt, 2);
      chk_int("idle gap cycles", idle, 1);
      check_digit(0, 8'hA4, "42 d0");
      check_digit(1, 8'h99, "42 d1");
      check_digit(2, LZ, "42 d2");
      check_digit(7, 8'hA4, "42 d7");

      // scan order and dwell
      found = 1'b0;
      prev_an = an;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (an == 8'hFE && prev_an == 8'h7F) begin
            found = 1'b1;
            break;
         end
         prev_an = an;
      end
      chk_int("scan sync", int'(found), 1);
      for (int d = 0; d < 8; d++) begin
         logic [7:0] want;
         int hold;
         want = ~(8'd1 << d);
         hold = 0;
         while (an == want && hold < 20) begin
            hold++;
            @(negedge clk);
         end
         chk_int($sformatf("scan dwell digit %0d", d), hold, SCAN_DIV);
      end
      chk8("scan wrap", an, 8'hFE);

      // value 7 and value 0, leading-zero handling
      sel = 2'd1; cnt_j = 16'd7;
      repeat (60) @(negedge clk);
      check_digit(0, 8'hF8, "7 d0");
      check_digit(1, LZ, "7 d1");
      check_digit(3, LZ, "7 d3");
      check_digit(4, LZ, "7 d4");
      @(negedge clk); cnt_j = 16'd0;
      repeat (90) @(negedge clk);
      check_digit(0, 8'hC0, "0 d0");
      check_digit(1, LZ, "0 d1");

      // reset during a conversion
      sync_phase(30);
      sel = 2'd2;
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk8("abort busy", {7'd0, busy}, 8'd0);
      chk8("abort an", an, 8'hFF);
      chk8("abort seg", seg, 8'hFF);
      chk8("abort upd", {7'd0, upd}, 8'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      wait_upd(40, c);
      chk_int("upd latency after abort", c, 19);
      check_digit(0, 8'hA4, "post-abort d0");
      check_digit(7, 8'hA4, "post-abort d7");

      // randomized traffic, checked cycle by cycle against the model
      for (int it = 0; it < 40; it++) begin
         int act;
         act = int'($urandom_range(0, 9));
         if (act <= 5) begin
            @(negedge clk);
            cnt_sum = rand_val(); cnt_j = rand_val(); cnt_b = rand_val(); cnt_bs = rand_val();
         end else if (act <= 8) begin
            @(negedge clk);
            sel = 2'($urandom_range(0, 3));
         end else begin
            @(posedge clk); #2 rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2 rst_n = 1'b1;
         end
         repeat ($urandom_range(1, 30)) @(negedge clk);
      end
      repeat (40) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
